// File: rtl/fir_pkg.sv
// Shared types and constants for the interleaved multi-channel FIR filter.
// Rounding/saturation on the output is enabled by defining FIR_ROUND_SAT_EN.
package fir_pkg;

  localparam int NR_STAGES_DEF = 32;
  localparam int DWIDTH_DEF    = 16;
  localparam int NR_CHAN_DEF   = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_MAC  = 3'd2,
    S_OUT  = 3'd3,
    S_WAIT = 3'd4
  } fir_state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // Full-precision products summed over every tap cannot overflow this width.
  function automatic int acc_width(input int nr_stages, input int dwidth);
    return 2 * dwidth + clog2(nr_stages);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate datapath and output scaling stage for fir_multichan.
// Defining FIR_ROUND_SAT_EN adds round-half-up and saturation to the output.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int ACCWIDTH  = acc_width(NR_STAGES_DEF, DWIDTH_DEF),
  parameter int OUT_SHIFT = DWIDTH - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DWIDTH-1:0] x,
  input  logic [DWIDTH-1:0] h,
  output logic [DWIDTH-1:0] result
);

  logic signed [2*DWIDTH-1:0] prod;
  logic signed [ACCWIDTH-1:0] prod_ext;
  logic signed [ACCWIDTH-1:0] acc;

  assign prod     = $signed(x) * $signed(h);
  assign prod_ext = {{(ACCWIDTH-2*DWIDTH){prod[2*DWIDTH-1]}}, prod};

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

`ifdef FIR_ROUND_SAT_EN
  // One extra bit of headroom so the rounding offset can never wrap the sum.
  localparam logic signed [ACCWIDTH:0] HALF    = {{ACCWIDTH{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  localparam logic signed [ACCWIDTH:0] SAT_MAX = {{(ACCWIDTH-DWIDTH+2){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [ACCWIDTH:0] SAT_MIN = {{(ACCWIDTH-DWIDTH+2){1'b1}}, {(DWIDTH-1){1'b0}}};

  logic signed [ACCWIDTH:0] rounded;
  logic signed [ACCWIDTH:0] shifted;

  always_comb begin
    rounded = {acc[ACCWIDTH-1], acc} + HALF;
    shifted = rounded >>> OUT_SHIFT;
    if (shifted > SAT_MAX) begin
      result = SAT_MAX[DWIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      result = SAT_MIN[DWIDTH-1:0];
    end else begin
      result = shifted[DWIDTH-1:0];
    end
  end
`else
  assign result = DWIDTH'(acc >>> OUT_SHIFT);
`endif

endmodule

// File: rtl/fir_multichan.sv
// Time-multiplexed FIR filter serving NR_CHAN interleaved channels, one MAC per cycle.
// Output rounding/saturation is selected by the FIR_ROUND_SAT_EN macro (see fir_mac).
module fir_multichan
  import fir_pkg::*;
#(
  parameter int NR_STAGES = NR_STAGES_DEF,
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int NR_CHAN   = NR_CHAN_DEF,
  parameter int OUT_SHIFT = DWIDTH - 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic                                   req_in,
  input  logic                                   ack_in,
  input  logic [DWIDTH-1:0]                      data_in,
  output logic                                   req_out,
  input  logic                                   ack_out,
  output logic [DWIDTH-1:0]                      data_out,
  output logic [max1(clog2(NR_CHAN))-1:0]        chan_out,
  input  logic [NR_STAGES*DWIDTH-1:0]            h_in,
  output logic [2:0]                             state_dbg
);

  // Handshakes are four-phase valid/ready: req_in/req_out are raised by this
  // block, an ack is acted on only while the matching req is high, and the
  // next sample is requested only after both acks have returned to 0.

  localparam int ACCWIDTH = acc_width(NR_STAGES, DWIDTH);
  localparam int CW       = max1(clog2(NR_CHAN));
  localparam int PW       = max1(clog2(NR_STAGES));
  localparam int DEPTH    = 1 << (CW + PW);

  fir_state_e state, state_nxt;

  logic [CW-1:0]     chan;
  logic [PW-1:0]     wp [NR_CHAN];
  logic [PW-1:0]     base;
  logic [PW-1:0]     tap;
  logic [PW-1:0]     rd_ptr;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] mac_x;
  logic [DWIDTH-1:0] mac_h;
  logic [DWIDTH-1:0] mac_result;
  logic              accept;
  logic              mac_last;
  logic              out_fire;

  assign accept    = (state == S_REQ) && ack_in;
  assign mac_last  = (state == S_MAC) && (tap == PW'(NR_STAGES - 1));
  assign out_fire  = (state == S_OUT) && req_out && ack_out;
  assign req_in    = (state == S_REQ);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ:  if (accept)   state_nxt = S_MAC;
      S_MAC:  if (mac_last) state_nxt = S_OUT;
      S_OUT:  if (out_fire) state_nxt = S_WAIT;
      S_WAIT: if (!ack_in && !ack_out) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  // x[n-k]: walk backwards from the newest sample, wrapping modulo NR_STAGES.
  always_comb begin
    if (tap <= base) begin
      rd_ptr = base - tap;
    end else begin
      rd_ptr = PW'({1'b0, base} + (PW+1)'(NR_STAGES) - {1'b0, tap});
    end
  end

  assign mac_x = mem[{chan, rd_ptr}];
  assign mac_h = h_in[int'(tap)*DWIDTH +: DWIDTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (accept) begin
      mem[{chan, wp[chan]}] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NR_CHAN; c++) begin
        wp[c] <= '0;
      end
      base     <= '0;
      tap      <= '0;
      chan     <= '0;
      req_out  <= 1'b0;
      data_out <= '0;
      chan_out <= '0;
    end else begin
      if (accept) begin
        base     <= wp[chan];
        wp[chan] <= (wp[chan] == PW'(NR_STAGES - 1)) ? '0 : wp[chan] + 1'b1;
        tap      <= '0;
      end
      if (state == S_MAC) begin
        tap <= tap + 1'b1;
      end
      // First OUT cycle: the accumulator is final, publish the result.
      if ((state == S_OUT) && !req_out) begin
        req_out  <= 1'b1;
        data_out <= mac_result;
        chan_out <= chan;
      end
      if (out_fire) begin
        req_out <= 1'b0;
        chan    <= (chan == CW'(NR_CHAN - 1)) ? '0 : chan + 1'b1;
      end
    end
  end

  fir_mac #(
    .DWIDTH   (DWIDTH),
    .ACCWIDTH (ACCWIDTH),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (state == S_MAC),
    .x     (mac_x),
    .h     (mac_h),
    .result(mac_result)
  );

endmodule

// File: tb/tb_fir_multichan.sv
// Self-checking bench for fir_multichan: impulse, random, saturation, latency,
// backpressure and mid-MAC reset, with a reference model and expected queue.
module tb_fir_multichan;
  import fir_pkg::*;

  localparam int NS  = 4;
  localparam int DW  = 16;
  localparam int NCH = 2;
  localparam int OSH = 15;

  logic            clk;
  logic            rst;
  logic            req_in;
  logic            ack_in;
  logic [DW-1:0]   data_in;
  logic            req_out;
  logic            ack_out;
  logic [DW-1:0]   data_out;
  logic [0:0]      chan_out;
  logic [NS*DW-1:0] h_in;
  logic [2:0]      state_dbg;

  fir_multichan #(
    .NR_STAGES(NS),
    .DWIDTH   (DW),
    .NR_CHAN  (NCH),
    .OUT_SHIFT(OSH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .ack_in   (ack_in),
    .data_in  (data_in),
    .req_out  (req_out),
    .ack_out  (ack_out),
    .data_out (data_out),
    .chan_out (chan_out),
    .h_in     (h_in),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];

  typedef struct {
    logic [DW-1:0] din;
    logic          chan;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t   imp_tab[10];
  longint hcoef[NS];
  longint hist[NCH][NS];
  int     mchan;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) check("req_exclusive", 32'(req_in & req_out), 32'd0);
  end

  task automatic set_h(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                       input logic [DW-1:0] c2, input logic [DW-1:0] c3);
    h_in = {c3, c2, c1, c0};
    hcoef[0] = longint'($signed(c0));
    hcoef[1] = longint'($signed(c1));
    hcoef[2] = longint'($signed(c2));
    hcoef[3] = longint'($signed(c3));
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NS; k++) hist[c][k] = 0;
    mchan = 0;
  endtask

  // Direct-form convolution over the per-channel history, then output scaling.
  task automatic model_step(input logic [DW-1:0] d, output logic [DW:0] e);
    longint s;
    longint r;
    logic [63:0] rb;
    for (int k = NS - 1; k > 0; k--) hist[mchan][k] = hist[mchan][k-1];
    hist[mchan][0] = longint'($signed(d));
    s = 0;
    for (int k = 0; k < NS; k++) s += hist[mchan][k] * hcoef[k];
`ifdef FIR_ROUND_SAT_EN
    r = (s + 64'sd16384) >>> OSH;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`else
    r = s >>> OSH;
`endif
    rb = r;
    e = {mchan[0], rb[DW-1:0]};
    mchan = (mchan + 1) % NCH;
  endtask

  // driver: one full sample round-trip including latency and backpressure checks
  task automatic run_txn(input logic [DW-1:0] d, input logic [DW:0] e, input int hold);
    int n;
    logic [DW:0] got;
    logic [DW:0] snap;
    n = 0;
    while (req_in !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_in_ready", 32'(req_in), 32'd1);
    if (req_in !== 1'b1) return;
    data_in = d;
    ack_in  = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check("req_in_cleared", 32'(req_in), 32'd0);
    @(negedge clk);
    ack_in  = 1'b0;
    data_in = DW'($urandom_range(0, 65535));
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (req_out !== 1'b1 && n < 100);
    check("latency", 32'(n), 32'(NS + 1));
    if (req_out !== 1'b1) begin
      void'(exp_q.pop_front());
      return;
    end
    @(negedge clk);
    snap = {chan_out, data_out};
    ack_in = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_stable", {14'd0, req_in, req_out, chan_out, data_out}, {14'd0, 1'b0, 1'b1, snap});
    end
    ack_in = 1'b0;
    got = exp_q.pop_front();
    check("data_out", 32'(data_out), 32'(got[DW-1:0]));
    check("chan_out", 32'(chan_out), 32'(got[DW]));
    ack_out = 1'b1;
    @(posedge clk);
    #1;
    check("req_out_cleared", 32'(req_out), 32'd0);
    @(negedge clk);
    ack_out = 1'b0;
  endtask

  task automatic fill_impulse();
    logic [DW-1:0] ch0_exp[5];
`ifdef FIR_ROUND_SAT_EN
    ch0_exp = '{16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0000};
`else
    ch0_exp = '{16'h3FFF, 16'h1FFF, 16'h0FFF, 16'h07FF, 16'h0000};
`endif
    for (int i = 0; i < 10; i++) begin
      imp_tab[i].din  = (i == 0) ? 16'h7FFF : 16'h0000;
      imp_tab[i].chan = i[0];
      imp_tab[i].dout = (i % 2 == 0) ? ch0_exp[i/2] : 16'h0000;
    end
  endtask

  task automatic run_impulse();
    logic [DW:0] m;
    for (int i = 0; i < 10; i++) begin
      model_step(imp_tab[i].din, m);
      run_txn(imp_tab[i].din, {imp_tab[i].chan, imp_tab[i].dout}, (i == 3) ? 10 : 0);
    end
  endtask

  initial begin
    logic [DW:0]   m;
    logic [DW-1:0] d;
    logic [DW-1:0] sat4;
    int n;
`ifdef FIR_ROUND_SAT_EN
    sat4 = 16'h7FFF;
`else
    sat4 = 16'hFFF8;
`endif
    rst     = 1'b0;
    ack_in  = 1'b0;
    ack_out = 1'b0;
    data_in = '0;
    set_h(16'h4000, 16'h2000, 16'h1000, 16'h0800);
    fill_impulse();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_in", 32'(req_in), 32'd0);
    check("rst_req_out", 32'(req_out), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_chan_out", 32'(chan_out), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    run_impulse();

    for (int i = 0; i < 8; i++) begin
      d = DW'($urandom_range(0, 65535));
      model_step(d, m);
      run_txn(d, m, $urandom_range(0, 3));
    end

    // saturation: coefficients may only change while the block sits in reset/IDLE
    @(negedge clk);
    rst = 1'b0;
    set_h(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      d = (i % 2 == 0) ? 16'h7FFF : 16'h0000;
      model_step(d, m);
      if (i == 6) m = {1'b0, sat4};
      run_txn(d, m, 0);
    end

    // mid-MAC reset: abandon the result, then the impulse response must repeat exactly
    n = 0;
    while (req_in !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midmac_req_in", 32'(req_in), 32'd1);
    data_in = 16'h1234;
    ack_in  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midmac_in_mac", 32'(state_dbg), 32'(S_MAC));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midmac_req_in_0", 32'(req_in), 32'd0);
    check("midmac_req_out_0", 32'(req_out), 32'd0);
    check("midmac_data_out_0", 32'(data_out), 32'd0);
    check("midmac_chan_out_0", 32'(chan_out), 32'd0);
    check("midmac_state", 32'(state_dbg), 32'(S_IDLE));
    set_h(16'h4000, 16'h2000, 16'h1000, 16'h0800);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    run_impulse();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_multichan.md
FIR_MULTICHAN -- requirements
Module: fir_multichan

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter NR_STAGES SHALL default to 32; it is the number of taps, minimum 2.
REQ-003 Parameter DWIDTH SHALL default to 16; it is the sample and coefficient width, signed two's complement.
REQ-004 Parameter NR_CHAN SHALL default to 4; it is the number of interleaved channels, minimum 1.
REQ-005 Parameter OUT_SHIFT SHALL default to DWIDTH-1; it is the arithmetic right shift from accumulator to output, minimum 1.
REQ-006 Derived constant ACCWIDTH SHALL be 2*DWIDTH+clog2(NR_STAGES).
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  synchronous active-low reset; 0 sampled at a clk edge resets the block.
REQ-009 req_in  output  1  block requests an input sample.
REQ-010 ack_in  input  1  upstream presents a valid data_in.
REQ-011 data_in  input  DWIDTH  signed input sample for the current channel.
REQ-012 req_out  output  1  output sample valid.
REQ-013 ack_out  input  1  downstream accepts the output.
REQ-014 data_out  output  DWIDTH  signed filtered sample.
REQ-015 chan_out  output  max(1,clog2(NR_CHAN))  channel index of data_out.
REQ-016 h_in  input  NR_STAGES*DWIDTH  coefficients shared by all channels; coefficient k occupies h_in[k*DWIDTH +: DWIDTH]; the bus is static while the block is not in IDLE.

Function
REQ-017 The state machine SHALL have states IDLE, REQ, MAC, OUT and WAIT.
REQ-018 IDLE SHALL go to REQ after one cycle.
REQ-019 In REQ, req_in SHALL be 1.
REQ-020 On the edge where req_in=1 and ack_in=1, the block SHALL write data_in into the delay line of the current channel at that channel's write pointer, clear req_in, clear acc and set tap k=0, then enter MAC.
REQ-021 In MAC, the block SHALL perform one multiply-accumulate per cycle: acc += x[n-k]*h[k], where x[n] is the newest sample; after NR_STAGES cycles it SHALL enter OUT.
REQ-022 Each channel SHALL keep its own circular delay line of NR_STAGES samples; the write pointer SHALL wrap from NR_STAGES-1 to 0, and x[n-k] reads SHALL wrap modulo NR_STAGES.
REQ-023 req_out SHALL rise exactly NR_STAGES+1 clk edges after the edge that accepted ack_in.
REQ-024 data_out and chan_out SHALL be registered at that same edge.
REQ-025 In OUT, req_out, data_out and chan_out SHALL hold stable until ack_out=1.
REQ-026 On the edge with req_out=1 and ack_out=1, the block SHALL clear req_out, advance the channel (NR_CHAN-1 wraps to 0) and enter WAIT.
REQ-027 WAIT SHALL go to REQ on the first edge with ack_in=0 and ack_out=0 (four-phase handshake).
REQ-028 ack_in while req_in=0, and ack_out while req_out=0, SHALL be ignored.
REQ-029 req_in and req_out SHALL never be 1 simultaneously.
REQ-030 Products SHALL be full 2*DWIDTH signed and the accumulator SHALL be ACCWIDTH bits wide with no internal overflow.
REQ-031 Without the configuration macro, data_out SHALL be (acc >>> OUT_SHIFT) truncated to the low DWIDTH bits.

Reset
REQ-032 When rst=0 at an edge, the block SHALL set: state=IDLE, req_in=0, req_out=0, data_out=0, chan_out=0, acc=0, all write pointers=0 and every delay-line entry=0.
REQ-033 Reset asserted in any state, including mid-MAC or mid-OUT, SHALL abandon the operation without emitting a partial result.

Configuration
REQ-034 The macro SHALL be named FIR_ROUND_SAT_EN.
REQ-035 With FIR_ROUND_SAT_EN defined, the block SHALL add 2^(OUT_SHIFT-1) before shifting and SHALL saturate the result to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
REQ-036 Without FIR_ROUND_SAT_EN, the output SHALL truncate and wrap as in REQ-031, and no rounding/saturation logic SHALL be present.

Structure
REQ-037 Package fir_pkg SHALL hold the state enum, a clog2 function, the default parameter values and the ACCWIDTH derivation.
REQ-038 Sub-module fir_mac SHALL contain the multiplier, accumulator and the output round/saturate stage.
REQ-039 The delay lines SHALL be a single NR_CHAN*NR_STAGES memory addressed as {channel, pointer}.

Verification
Common settings: NR_STAGES=4, DWIDTH=16, NR_CHAN=2, OUT_SHIFT=15, h={0x4000,0x2000,0x1000,0x0800}.
REQ-040 Impulse test: ch0 gets 0x7FFF then zeros, ch1 gets zeros -> ch0 outputs 0x3FFF,0x1FFF,0x0FFF,0x07FF, then 0 without the macro; 0x4000,0x2000,0x1000,0x0800 with it; all ch1 outputs are 0 and chan_out alternates 0,1.
REQ-041 Saturation test: all h=0x7FFF, ch0 gets 0x7FFF four times -> the fourth ch0 output is 0x7FFF with FIR_ROUND_SAT_EN and 0xFFF8 without it.
REQ-042 Latency test: ack_in accepted at edge E -> req_out first seen high after edge E+5.
REQ-043 Backpressure test: ack_out held at 0 for 10 cycles -> req_out, data_out and chan_out stay constant, and req_in stays 0.
REQ-044 Mid-MAC reset test: rst=0 on the 2nd MAC cycle -> next cycle all outputs are 0; the following impulse test reproduces REQ-040 exactly, with no residue from the delay line.
